// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_t;

    // A digit at or above the threshold would overflow 9 after the next doubling.
    localparam bcd_digit_t ADJ_THRESH = 4'd5;
    localparam bcd_digit_t ADJ_ADD    = 4'd3;

    // Number of decimal digits required to hold 2**bin_w - 1.
    function automatic int bcd_digits_needed(input int bin_w);
        longint unsigned max_v;
        int              n;
        max_v = (64'd1 << bin_w) - 64'd1;
        n     = 1;
        while (max_v >= 64'd10) begin
            max_v = max_v / 64'd10;
            n     = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit's pre-shift correction: add 3 when the digit is 5 or more.
// The add is a plain 4-bit add; no carry leaves the digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_out
);

    // Correct the digit so that the following left shift lands on a valid BCD value.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADJ_THRESH) begin
            digit_out = digit_in + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// A conversion takes BIN_W cycles; bcd_out is registered and only changes on
// the completion edge, so downstream digit decoders never see partial results.
// Optional feature: define BCD_BLANK_EN to add the blank_mask output, which
// flags leading-zero digits (digit 0 is never blanked).
//
// Handshake: start is sampled only while idle (busy low); start while busy is
// dropped. done pulses for one cycle when bcd_out takes the new result, and a
// start in that same cycle is accepted, giving back-to-back conversions.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank_mask
`endif
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SCR_W = 4 * DIGITS;
    localparam int TOT_W = SCR_W + BIN_W;

    // The largest input must fit in the configured digit count.
    if (bcd_digits_needed(BIN_W) > DIGITS) begin : g_digits_check
        $error("bin2bcd_seq: DIGITS too small for BIN_W");
    end

    conv_state_t        state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;

    logic [SCR_W-1:0]   scratch_adj;
    logic [TOT_W-1:0]   shifted;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scratch_q[4*k +: 4]),
            .digit_out (scratch_adj[4*k +: 4])
        );
    end

    assign shifted = {scratch_adj, bin_q} << 1;

`ifdef BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    logic [DIGITS-1:0] blank_q, blank_d, blank_next;
    logic              all_zero;

    // A digit is blank when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        blank_next = '0;
        all_zero   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero      = all_zero && (shifted[BIN_W + 4*k +: 4] == 4'd0);
            blank_next[k] = all_zero;
        end
    end
`endif

    // Next-state and datapath control for the IDLE/SHIFT sequencer.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
`ifdef BCD_BLANK_EN
        blank_d   = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d     = bin_in;
                    scratch_d = '0;
                    count_d   = CNT_W'(BIN_W);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[TOT_W-1:BIN_W];
                bin_d     = shifted[BIN_W-1:0];
                count_d   = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    bcd_d   = shifted[TOT_W-1:BIN_W];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef BCD_BLANK_EN
                    blank_d = blank_next;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
`ifdef BCD_BLANK_EN
            blank_q   <= BLANK_RST;
`endif
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
`ifdef BCD_BLANK_EN
            blank_q   <= blank_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
`ifdef BCD_BLANK_EN
    assign blank_mask = blank_q;
`endif

endmodule
